// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pong_pkg
//  Description : Shared paddle geometry and quadrature direction encoding
//                for the pong game logic.
//  Revision    : 1.0 - initial release
// ============================================================================
package pong_pkg;

    localparam int POS_W        = 9;
    localparam int PADDLE_STEP  = 4;
    localparam int PADDLE_MIN   = 0;
    localparam int PADDLE_MAX   = 508;
    localparam int PADDLE_RESET = 256;

    // Encoding matches the modulo-4 phase difference (cur - prev), which keeps
    // the decoder a plain subtraction.
    typedef enum logic [1:0] {
        QD_NONE = 2'd0,
        QD_FWD  = 2'd1,
        QD_ILL  = 2'd2,
        QD_REV  = 2'd3
    } qd_dir_t;

    // Gray state {a,b} to phase index: 00->0, 01->1, 11->2, 10->3.
    function automatic logic [1:0] gray_to_phase(input logic [1:0] g);
        return {g[1], g[1] ^ g[0]};
    endfunction

    // Classifies one transition of the filtered encoder pins.
    function automatic qd_dir_t qd_decode(input logic [1:0] prev,
                                          input logic [1:0] cur);
        logic [1:0] diff;
        diff = gray_to_phase(cur) - gray_to_phase(prev);
        case (diff)
            2'd0:    return QD_NONE;
            2'd1:    return QD_FWD;
            2'd2:    return QD_ILL;
            default: return QD_REV;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_glitch_filter.sv
`default_nettype none
// ============================================================================
//  Module      : sync_glitch_filter
//  Description : Two-flop synchroniser followed by a stability filter. The
//                filtered output only follows the synchronised input after it
//                has differed for FILT_CYCLES consecutive cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_glitch_filter #(
    parameter int FILT_CYCLES = 8
) (
    input  logic clk25,
    input  logic rst_n,
    input  logic i_din,
    output logic o_sync,
    output logic o_filt
);

    localparam int c_cnt_w = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(FILT_CYCLES - 1);

    logic               r_meta;
    logic               r_sync;
    logic               r_filt;
    logic [c_cnt_w-1:0] r_cnt;

    // Plain two-flop synchroniser for the asynchronous pin.
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_din;
            r_sync <= r_meta;
        end
    end

    // Stability counter: any return to the filtered value restarts the count.
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            r_filt <= 1'b0;
            r_cnt  <= '0;
        end else if (r_sync != r_filt) begin
            if (r_cnt == c_last) begin
                r_filt <= r_sync;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + c_cnt_w'(1);
            end
        end else begin
            r_cnt <= '0;
        end
    end

    assign o_sync = r_sync;
    assign o_filt = r_filt;

endmodule
`default_nettype wire

// File: rtl/paddle_quad_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : paddle_quad_decoder
//  Description : Rotary-encoder front end for the paddle. Filters both pins,
//                decodes Gray-code quadrature, accumulates edges into steps,
//                saturates the position at the playfield limits and keeps a
//                frame-stable copy of the position.
//  Revision    : 1.0 - initial release
// ============================================================================
module paddle_quad_decoder #(
    parameter int POS_W          = pong_pkg::POS_W,
    parameter int STEP           = pong_pkg::PADDLE_STEP,
    parameter int POS_MIN        = pong_pkg::PADDLE_MIN,
    parameter int POS_MAX        = pong_pkg::PADDLE_MAX,
    parameter int RESET_POS      = pong_pkg::PADDLE_RESET,
    parameter int FILT_CYCLES    = 8,
    parameter int EDGES_PER_STEP = 1
) (
    input  logic             clk25,
    input  logic             rst_n,
    input  logic             rota,
    input  logic             rotb,
    input  logic             frame_strobe,
    output logic [POS_W-1:0] paddle_pos,
    output logic [POS_W-1:0] paddle_pos_frame,
    output logic             move_pulse,
    output logic             move_dir,
    output logic             sat_pulse,
    output logic             armed,
    output logic [7:0]       err_cnt
);

    import pong_pkg::*;

    localparam logic [POS_W:0]     c_step      = (POS_W+1)'(STEP);
    localparam logic [POS_W:0]     c_min       = (POS_W+1)'(POS_MIN);
    localparam logic [POS_W:0]     c_max       = (POS_W+1)'(POS_MAX);
    localparam logic [POS_W-1:0]   c_reset_pos = POS_W'(RESET_POS);
    localparam logic signed [3:0]  c_eps_pos   = 4'(EDGES_PER_STEP);
    localparam logic signed [3:0]  c_eps_neg   = 4'(-EDGES_PER_STEP);

    logic w_sync_a, w_filt_a;
    logic w_sync_b, w_filt_b;

    sync_glitch_filter #(.FILT_CYCLES(FILT_CYCLES)) u_filt_a (
        .clk25  (clk25),
        .rst_n  (rst_n),
        .i_din  (rota),
        .o_sync (w_sync_a),
        .o_filt (w_filt_a)
    );

    sync_glitch_filter #(.FILT_CYCLES(FILT_CYCLES)) u_filt_b (
        .clk25  (clk25),
        .rst_n  (rst_n),
        .i_din  (rotb),
        .o_sync (w_sync_b),
        .o_filt (w_filt_b)
    );

    logic [1:0]        r_warm;
    logic              r_armed;
    logic [1:0]        r_prev;
    logic signed [3:0] r_acc;
    logic [7:0]        r_err;
    logic              r_req_up;
    logic              r_req_dn;
    logic [POS_W-1:0]  r_pos;
    logic [POS_W-1:0]  r_pos_frame;
    logic              r_move;
    logic              r_dir;
    logic              r_sat;

    logic [1:0]        w_cur;
    logic              w_warm_done;
    logic              w_stable;
    qd_dir_t           w_qd;
    logic signed [3:0] w_delta;
    logic signed [3:0] w_acc_sum;
    logic [POS_W:0]    w_pos_ext;
    logic [POS_W:0]    w_up_sum;
    logic [POS_W:0]    w_next_ext;
    logic [POS_W-1:0]  w_pos_next;
    logic              w_at_limit;

    // Quadrature classification of the filtered pins and accumulator preview.
    always_comb begin
        w_cur       = {w_filt_a, w_filt_b};
        // Right after reset the synchroniser still holds its reset zeros, so
        // equality with the filter is meaningless until two clocks have passed.
        w_warm_done = (r_warm == 2'd2);
        w_stable    = (w_sync_a == w_filt_a) && (w_sync_b == w_filt_b);
        w_qd        = qd_decode(r_prev, w_cur);
        w_delta     = 4'sd0;
        case (w_qd)
            QD_FWD:  w_delta = 4'sd1;
            QD_REV:  w_delta = -4'sd1;
            default: w_delta = 4'sd0;
        endcase
        w_acc_sum = r_acc + w_delta;
    end

    // Arming, edge decode, illegal-transition counting and step requests.
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            r_warm   <= 2'd0;
            r_armed  <= 1'b0;
            r_prev   <= 2'b00;
            r_acc    <= 4'sd0;
            r_err    <= 8'd0;
            r_req_up <= 1'b0;
            r_req_dn <= 1'b0;
        end else begin
            r_req_up <= 1'b0;
            r_req_dn <= 1'b0;
            if (!w_warm_done) begin
                r_warm <= r_warm + 2'd1;
            end
            if (!r_armed) begin
                if (w_warm_done && w_stable) begin
                    r_armed <= 1'b1;
                    r_prev  <= w_cur;
                end
            end else begin
                r_prev <= w_cur;
                if (w_qd == QD_ILL) begin
                    if (r_err != 8'hFF) begin
                        r_err <= r_err + 8'd1;
                    end
                end else if (w_acc_sum == c_eps_pos) begin
                    r_req_up <= 1'b1;
                    r_acc    <= 4'sd0;
                end else if (w_acc_sum == c_eps_neg) begin
                    r_req_dn <= 1'b1;
                    r_acc    <= 4'sd0;
                end else begin
                    r_acc <= w_acc_sum;
                end
            end
        end
    end

    // Saturating next position, computed one bit wider so it can never wrap.
    always_comb begin
        w_pos_ext  = {1'b0, r_pos};
        w_up_sum   = w_pos_ext + c_step;
        w_next_ext = w_pos_ext;
        w_at_limit = 1'b0;
        if (r_req_up) begin
            w_next_ext = (w_up_sum > c_max) ? c_max : w_up_sum;
            w_at_limit = (w_next_ext == c_max);
        end else if (r_req_dn) begin
            w_next_ext = (w_pos_ext < c_min + c_step) ? c_min : (w_pos_ext - c_step);
            w_at_limit = (w_next_ext == c_min);
        end
        w_pos_next = w_next_ext[POS_W-1:0];
    end

    // Position register, status pulses and the frame-stable copy.
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            r_pos       <= c_reset_pos;
            r_pos_frame <= c_reset_pos;
            r_move      <= 1'b0;
            r_dir       <= 1'b0;
            r_sat       <= 1'b0;
        end else begin
            r_pos  <= w_pos_next;
            r_move <= (w_pos_next != r_pos);
            // A step that ends on a limit, clipped or landing exactly, flags sat.
            r_sat  <= (r_req_up || r_req_dn) && w_at_limit;
            if (r_req_up) begin
                r_dir <= 1'b1;
            end else if (r_req_dn) begin
                r_dir <= 1'b0;
            end
            // Captures the registered value, so a coincident update is not seen.
            if (frame_strobe) begin
                r_pos_frame <= r_pos;
            end
        end
    end

    assign paddle_pos       = r_pos;
    assign paddle_pos_frame = r_pos_frame;
    assign move_pulse       = r_move;
    assign move_dir         = r_dir;
    assign sat_pulse        = r_sat;
    assign armed            = r_armed;
    assign err_cnt          = r_err;

endmodule
`default_nettype wire

// File: tb/tb_paddle_quad_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_paddle_quad_decoder
//  Description : Directed self-checking bench for paddle_quad_decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_paddle_quad_decoder;

    logic       clk25 = 1'b0;
    logic       rst_n;
    logic       rota;
    logic       rotb;
    logic       frame_strobe;
    logic [8:0] paddle_pos;
    logic [8:0] paddle_pos_frame;
    logic       move_pulse;
    logic       move_dir;
    logic       sat_pulse;
    logic       armed;
    logic [7:0] err_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int move_seen = 0;
    int sat_seen  = 0;
    int phase;
    int m0;
    int s0;
    logic [1:0] gray_seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    always #5 clk25 = ~clk25;

    paddle_quad_decoder dut (
        .clk25            (clk25),
        .rst_n            (rst_n),
        .rota             (rota),
        .rotb             (rotb),
        .frame_strobe     (frame_strobe),
        .paddle_pos       (paddle_pos),
        .paddle_pos_frame (paddle_pos_frame),
        .move_pulse       (move_pulse),
        .move_dir         (move_dir),
        .sat_pulse        (sat_pulse),
        .armed            (armed),
        .err_cnt          (err_cnt)
    );

    // Pulse counters sampled mid-cycle.
    always @(negedge clk25) begin
        if (rst_n === 1'b1) begin
            if (move_pulse === 1'b1) move_seen++;
            if (sat_pulse === 1'b1)  sat_seen++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Move the encoder one Gray state forward (+1) or backward (-1).
    task automatic quad_edge(input int dir);
        phase = (phase + dir + 4) % 4;
        @(negedge clk25);
        {rota, rotb} = gray_seq[phase];
    endtask

    task automatic step_edge(input int dir);
        quad_edge(dir);
        repeat (12) @(posedge clk25);
    endtask

    initial begin
        rota = 1'b1; rotb = 1'b1; frame_strobe = 1'b0; rst_n = 1'b0; phase = 2;
        repeat (3) @(posedge clk25);
        #1;
        chk("rst_pos",   paddle_pos, 256);
        chk("rst_frame", paddle_pos_frame, 256);
        chk("rst_armed", armed, 0);
        chk("rst_err",   err_cnt, 0);
        chk("rst_move",  move_pulse, 0);
        chk("rst_sat",   sat_pulse, 0);
        chk("rst_dir",   move_dir, 0);

        // Arming with both pins held high: 2 + 8 + 1 cycles.
        @(negedge clk25) rst_n = 1'b1;
        repeat (10) @(posedge clk25);
        #1 chk("armed_early", armed, 0);
        @(posedge clk25);
        #1 chk("armed_on_time", armed, 1);

        // Four forward edges, first one timed to the cycle.
        m0 = move_seen;
        quad_edge(1);
        repeat (11) @(posedge clk25);
        #1 chk("lat_before", paddle_pos, 256);
        @(posedge clk25);
        #1 chk("lat_pos", paddle_pos, 260);
        chk("lat_move", move_pulse, 1);
        chk("lat_dir", move_dir, 1);
        repeat (8) @(posedge clk25);
        for (int i = 0; i < 3; i++) begin
            quad_edge(1);
            repeat (20) @(posedge clk25);
        end
        #1 chk("fwd4_pos", paddle_pos, 272);
        chk("fwd4_moves", move_seen - m0, 4);
        chk("fwd4_dir", move_dir, 1);

        // Five-cycle glitch on rota must be swallowed.
        m0 = move_seen;
        @(negedge clk25) rota = 1'b0;
        repeat (5) @(posedge clk25);
        @(negedge clk25) rota = 1'b1;
        repeat (20) @(posedge clk25);
        #1 chk("glitch_moves", move_seen - m0, 0);
        chk("glitch_err", err_cnt, 0);
        chk("glitch_pos", paddle_pos, 272);

        // Both pins toggle together: 11 -> 00 is illegal.
        m0 = move_seen;
        @(negedge clk25) {rota, rotb} = 2'b00;
        phase = 0;
        repeat (20) @(posedge clk25);
        #1 chk("ill_err", err_cnt, 1);
        chk("ill_pos", paddle_pos, 272);
        chk("ill_moves", move_seen - m0, 0);

        // 70 forward steps from 272: reaches 508 on step 59.
        m0 = move_seen; s0 = sat_seen;
        for (int i = 0; i < 70; i++) step_edge(1);
        repeat (2) @(posedge clk25);
        #1 chk("up_pos", paddle_pos, 508);
        chk("up_moves", move_seen - m0, 59);
        chk("up_sats", sat_seen - s0, 12);
        chk("up_dir", move_dir, 1);

        // 130 reverse steps from 508: reaches 0 on step 127.
        m0 = move_seen; s0 = sat_seen;
        for (int i = 0; i < 130; i++) step_edge(-1);
        repeat (2) @(posedge clk25);
        #1 chk("dn_pos", paddle_pos, 0);
        chk("dn_moves", move_seen - m0, 127);
        chk("dn_sats", sat_seen - s0, 4);
        chk("dn_dir", move_dir, 0);
        chk("dn_err", err_cnt, 1);

        // Asynchronous reset mid-operation, no clock edge before sampling.
        @(posedge clk25);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_pos", paddle_pos, 256);
        chk("arst_frame", paddle_pos_frame, 256);
        chk("arst_err", err_cnt, 0);
        chk("arst_armed", armed, 0);
        chk("arst_move", move_pulse, 0);

        // Re-arm with pins at 00, then one step to 260.
        @(negedge clk25) rst_n = 1'b1;
        repeat (6) @(posedge clk25);
        #1 chk("rearm", armed, 1);
        step_edge(1);
        #1 chk("step_260", paddle_pos, 260);

        // Frame strobe coincident with the 260 -> 264 update.
        quad_edge(1);
        repeat (11) @(posedge clk25);
        @(negedge clk25) frame_strobe = 1'b1;
        @(posedge clk25);
        #1 chk("coinc_pos", paddle_pos, 264);
        chk("coinc_frame", paddle_pos_frame, 260);
        @(negedge clk25) frame_strobe = 1'b0;
        repeat (3) @(posedge clk25);
        @(negedge clk25) frame_strobe = 1'b1;
        @(negedge clk25) frame_strobe = 1'b0;
        #1 chk("next_frame", paddle_pos_frame, 264);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
